// File: rtl/cell_test_pkg.sv
// Shared FSM encoding, field widths and vector helper for the standard-cell self-test sequencer.
package cell_test_pkg;

  localparam int NIN_W    = 2;
  localparam int VEC_W    = 3;
  localparam int TT_W     = 8;
  localparam int CUT_IN_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Highest input vector for a cell with nin inputs (2^nin - 1).
  function automatic logic [VEC_W-1:0] last_vec(input logic [NIN_W-1:0] nin);
    case (nin)
      2'd0:    last_vec = 3'd0;
      2'd1:    last_vec = 3'd1;
      2'd2:    last_vec = 3'd3;
      default: last_vec = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/cell_test_next_cell.sv
// Combinational lowest-index search for the next enabled cell after cur (or at cur when incl_cur).
// none is raised when no enabled cell remains; zero latency, no flow control.
module cell_test_next_cell #(
  parameter int NCELLS = 11
) (
  input  logic [NCELLS-1:0] en,
  input  logic [3:0]        cur,
  input  logic              incl_cur,
  output logic [3:0]        nxt,
  output logic              none
);

  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = 0; i < NCELLS; i++) begin
      if (none && en[i] && ((i > int'(cur)) || (incl_cur && (i == int'(cur))))) begin
        nxt  = 4'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cell_test_sequencer.sv
// Self-test sequencer: walks every input vector of each enabled CUT, settles, samples and scores it.
// Per-vector latency settle+2 cycles (settle+4 with the CELL_TEST_SYNC_EN output synchronizer); start ignored while busy.
module cell_test_sequencer
  import cell_test_pkg::*;
#(
  parameter int NCELLS = 11,
  parameter int CNT_W  = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       start_i,
  input  logic [7:0]                 settle_i,
  input  logic [NIN_W*NCELLS-1:0]    nin_i,
  input  logic [TT_W*NCELLS-1:0]     tt_i,
  input  logic [NCELLS-1:0]          cut_out_i,
  output logic [CUT_IN_W*NCELLS-1:0] cut_in_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [NCELLS-1:0]          pass_o,
  output logic [CNT_W-1:0]           fail_cnt_o,
  output logic [3:0]                 cur_cell_o,
  output logic [VEC_W-1:0]           cur_vec_o
);

  state_t                  state_q, state_d;
  logic [3:0]              cell_q, cell_d;
  logic [VEC_W-1:0]        vec_q, vec_d;
  logic [8:0]              cnt_q, cnt_d;
  logic [7:0]              settle_q, settle_d;
  logic [NIN_W*NCELLS-1:0] nin_q, nin_d;
  logic [TT_W*NCELLS-1:0]  tt_q, tt_d;
  logic [NCELLS-1:0]       pass_q, pass_d;
  logic [CNT_W-1:0]        fail_q, fail_d;

  logic [NCELLS-1:0] en_live, en_cap, srch_en, cell_hot, cut_src;
  logic [3:0]        srch_nxt;
  logic              srch_none;
  logic [NIN_W-1:0]  cur_nin;
  logic [TT_W-1:0]   cur_tt;
  logic [8:0]        settle_load;
  logic              y_cmp;

`ifdef CELL_TEST_SYNC_EN
  logic [NCELLS-1:0] sync1_q, sync2_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= cut_out_i;
      sync2_q <= sync1_q;
    end
  end

  // Two extra settle cycles cover the synchronizer delay.
  assign cut_src     = sync2_q;
  assign settle_load = {1'b0, settle_q} + 9'd2;
`else
  assign cut_src     = cut_out_i;
  assign settle_load = {1'b0, settle_q};
`endif

  always_comb begin
    en_live  = '0;
    en_cap   = '0;
    cell_hot = '0;
    cur_nin  = '0;
    cur_tt   = '0;
    for (int c = 0; c < NCELLS; c++) begin
      en_live[c] = |nin_i[c*NIN_W +: NIN_W];
      en_cap[c]  = |nin_q[c*NIN_W +: NIN_W];
      if (cell_q == 4'(c)) begin
        cell_hot[c] = 1'b1;
        cur_nin     = nin_q[c*NIN_W +: NIN_W];
        cur_tt      = tt_q[c*TT_W +: TT_W];
      end
    end
  end

  assign y_cmp   = |(cut_src & cell_hot);
  assign srch_en = (state_q == ST_IDLE) ? en_live : en_cap;

  cell_test_next_cell #(.NCELLS(NCELLS)) u_next_cell (
    .en       (srch_en),
    .cur      ((state_q == ST_IDLE) ? 4'd0 : cell_q),
    .incl_cur (state_q == ST_IDLE),
    .nxt      (srch_nxt),
    .none     (srch_none)
  );

  always_comb begin
    state_d  = state_q;
    cell_d   = cell_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    nin_d    = nin_q;
    tt_d     = tt_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          settle_d = settle_i;
          nin_d    = nin_i;
          tt_d     = tt_i;
          pass_d   = en_live;
          fail_d   = '0;
          cell_d   = srch_nxt;
          vec_d    = '0;
          state_d  = srch_none ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        cnt_d   = settle_load;
        state_d = (settle_load == 9'd0) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q <= 9'd1) state_d = ST_SAMPLE;
        else               cnt_d   = cnt_q - 9'd1;
      end
      ST_SAMPLE: begin
        if (y_cmp != cur_tt[vec_q]) begin
          pass_d = pass_q & ~cell_hot;
          if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
        end
        if (vec_q < last_vec(cur_nin)) begin
          vec_d   = vec_q + 3'd1;
          state_d = ST_DRIVE;
        end else begin
          vec_d = '0;
          if (srch_none) begin
            state_d = ST_DONE;
          end else begin
            cell_d  = srch_nxt;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      cell_q   <= '0;
      vec_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      nin_q    <= '0;
      tt_q     <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      cell_q   <= cell_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      nin_q    <= nin_d;
      tt_q     <= tt_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  // Only the active cell is driven, and only while a vector is in flight.
  always_comb begin
    cut_in_o = '0;
    if (state_q inside {ST_DRIVE, ST_SETTLE, ST_SAMPLE}) begin
      for (int c = 0; c < NCELLS; c++) begin
        if (cell_hot[c]) cut_in_o[c*CUT_IN_W +: CUT_IN_W] = vec_q & last_vec(cur_nin);
      end
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign pass_o     = pass_q;
  assign fail_cnt_o = fail_q;
  assign cur_cell_o = cell_q;
  assign cur_vec_o  = vec_q;

endmodule

// File: tb/tb_cell_test_sequencer.sv
// Bench for cell_test_sequencer: step-list reference model, per-cycle compare, directed and random runs.
module tb_cell_test_sequencer;

  localparam int N  = 3;
  localparam int CW = 2;
`ifdef CELL_TEST_SYNC_EN
  localparam int SYNC_X = 2;
`else
  localparam int SYNC_X = 0;
`endif

  typedef logic [2*N-1:0] nin_t;
  typedef logic [8*N-1:0] tt_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    settle = '0;
  nin_t          nin = '0;
  tt_t           tt = '0;
  logic [N-1:0]  cut_out;
  logic [3*N-1:0] cut_in;
  logic          busy, done;
  logic [N-1:0]  pass;
  logic [CW-1:0] fail_cnt;
  logic [3:0]    cur_cell;
  logic [2:0]    cur_vec;
  logic [7:0]    cut_tt [N];
  bit            chk_en = 1'b0;

  always #5 clk = ~clk;

  cell_test_sequencer #(.NCELLS(N), .CNT_W(CW)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start),
    .settle_i   (settle),
    .nin_i      (nin),
    .tt_i       (tt),
    .cut_out_i  (cut_out),
    .cut_in_o   (cut_in),
    .busy_o     (busy),
    .done_o     (done),
    .pass_o     (pass),
    .fail_cnt_o (fail_cnt),
    .cur_cell_o (cur_cell),
    .cur_vec_o  (cur_vec)
  );

  // Silicon model: each cell's Y is a lookup of its real table by its applied inputs.
  always_comb begin
    for (int c = 0; c < N; c++) cut_out[c] = cut_tt[c][cut_in[3*c +: 3]];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: on start, list every (cell, vector) step; step j owns cycles j*P+1 .. (j+1)*P.
  bit           m_run = 1'b0;
  int           m_k = 0, m_S = 0, m_P = 2;
  int           m_cell [8*N];
  int           m_vec  [8*N];
  bit           m_mm   [8*N];
  logic [N-1:0] m_pass = '0;
  int           m_fail = 0;

  task automatic model_step();
    int j;
    logic [7:0] diff;
    if (rst) begin
      m_run  = 1'b0;
      m_k    = 0;
      m_pass = '0;
      m_fail = 0;
    end else if (m_run) begin
      if (m_k <= m_S*m_P && (m_k % m_P) == 0) begin
        j = m_k/m_P - 1;
        if (m_mm[j]) begin
          m_pass = m_pass & ~(N'(1) << m_cell[j]);
          if (m_fail < (1 << CW) - 1) m_fail++;
        end
      end
      if (m_k == m_S*m_P + 1) begin
        m_run = 1'b0;
        m_k   = 0;
      end else begin
        m_k++;
      end
    end else if (start) begin
      m_S    = 0;
      m_P    = int'(settle) + 2 + SYNC_X;
      m_pass = '0;
      m_fail = 0;
      for (int c = 0; c < N; c++) begin
        if (nin[2*c +: 2] != 2'd0) begin
          m_pass = m_pass | (N'(1) << c);
          diff   = cut_tt[c] ^ tt[8*c +: 8];
          for (int v = 0; v < (1 << nin[2*c +: 2]); v++) begin
            m_cell[m_S] = c;
            m_vec[m_S]  = v;
            m_mm[m_S]   = ((diff >> v) & 8'd1) != 8'd0;
            m_S++;
          end
        end
      end
      m_run = 1'b1;
      m_k   = 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin : cmp
    int j;
    bit act;
    logic [63:0] exp_cut;
    wait (chk_en);
    forever begin
      @(negedge clk);
      act     = m_run && (m_k <= m_S*m_P);
      exp_cut = '0;
      j       = 0;
      if (act) begin
        j       = (m_k - 1) / m_P;
        exp_cut = 64'(m_vec[j]) << (3*m_cell[j]);
      end
      chk("busy", 64'(busy), 64'(m_run));
      chk("done", 64'(done), 64'(m_run && (m_k == m_S*m_P + 1)));
      chk("pass", 64'(pass), 64'(m_pass));
      chk("fail_cnt", 64'(fail_cnt), 64'(m_fail));
      chk("cut_in", 64'(cut_in), exp_cut);
      if (act) begin
        chk("cur_cell", 64'(cur_cell), 64'(m_cell[j]));
        chk("cur_vec", 64'(cur_vec), 64'(m_vec[j]));
      end
    end
  end

  // Pulse start and wait for done; n counts cycles from the accepting edge.
  task automatic run(input string name, input int exp_cyc, input bit disturb, input int abort_at);
    int n = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!done && n < 2000) begin
      if (n == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (disturb && n == 3) begin
        start = 1'b1;
        nin   = nin_t'($urandom);
        tt    = tt_t'($urandom);
      end
      if (disturb && n == 4) start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({name, " done seen"}, 64'(done), 64'(1));
    if (exp_cyc > 0) chk({name, " cycles"}, 64'(n), 64'(exp_cyc));
    @(negedge clk);
  endtask

  task automatic setup(input logic [7:0] s, input nin_t n, input tt_t t);
    settle = s;
    nin    = n;
    tt     = t;
    for (int c = 0; c < N; c++) cut_tt[c] = t[8*c +: 8];
  endtask

  initial begin
    for (int c = 0; c < N; c++) cut_tt[c] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset cut_in", 64'(cut_in), 64'(0));
    chk("reset pass", 64'(pass), 64'(0));
    chk("reset fail_cnt", 64'(fail_cnt), 64'(0));
    rst    = 1'b0;
    chk_en = 1'b1;

    // cell0 AND2 (tt 08), cell1 INV (tt 01), cell2 disabled
    setup(8'd3, 6'b00_01_10, {8'h00, 8'h01, 8'h08});
    run("ideal", 6*(5 + SYNC_X) + 1, 1'b0, 0);
    chk("ideal pass", 64'(pass), 64'(3'b011));
    chk("ideal fail_cnt", 64'(fail_cnt), 64'(0));

    cut_tt[0] = 8'h00;
    run("stuck0", 6*(5 + SYNC_X) + 1, 1'b0, 0);
    chk("stuck0 pass", 64'(pass), 64'(3'b010));
    chk("stuck0 fail_cnt", 64'(fail_cnt), 64'(1));

    setup(8'd3, 6'b00_01_00, {8'h00, 8'h01, 8'h08});
    run("cell0 off", 2*(5 + SYNC_X) + 1, 1'b0, 0);
    chk("cell0 off pass", 64'(pass), 64'(3'b010));

    setup(8'd3, 6'b00_00_00, {8'h00, 8'h01, 8'h08});
    run("all off", 1, 1'b0, 0);
    chk("all off pass", 64'(pass), 64'(0));

    setup(8'd0, 6'b00_01_10, {8'h00, 8'h01, 8'h08});
    run("settle0 disturbed", 6*(2 + SYNC_X) + 1, 1'b1, 0);
    chk("settle0 pass", 64'(pass), 64'(3'b011));

    setup(8'd1, 6'b00_01_10, {8'h00, 8'h01, 8'h08});
    run("settle1", 6*(3 + SYNC_X) + 1, 1'b0, 0);

    // abort in SETTLE of vector 1 on cell0
    setup(8'd3, 6'b00_01_10, {8'h00, 8'h01, 8'h08});
    run("abort", 0, 1'b0, 8);
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    chk("abort cut_in", 64'(cut_in), 64'(0));
    chk("abort pass", 64'(pass), 64'(0));
    chk("abort fail_cnt", 64'(fail_cnt), 64'(0));
    chk("abort cur_cell", 64'(cur_cell), 64'(0));
    chk("abort cur_vec", 64'(cur_vec), 64'(0));
    run("after abort", 6*(5 + SYNC_X) + 1, 1'b0, 0);
    chk("after abort pass", 64'(pass), 64'(3'b011));

    // always-wrong 3-input cell saturates the 2-bit counter
    setup(8'd3, 6'b00_00_11, {8'h00, 8'h00, 8'h96});
    cut_tt[0] = 8'h69;
    run("saturate", 8*(5 + SYNC_X) + 1, 1'b0, 0);
    chk("saturate fail_cnt", 64'(fail_cnt), 64'(3));
    chk("saturate pass", 64'(pass), 64'(0));

    for (int it = 0; it < 30; it++) begin
      nin    = nin_t'($urandom);
      tt     = tt_t'($urandom);
      settle = 8'($urandom_range(0, 4));
      for (int c = 0; c < N; c++)
        cut_tt[c] = tt[8*c +: 8] ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      run("random", 0, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 20)) : 0);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cell_test_sequencer.md
Name: cell_test_sequencer

Overview:
- Automatic self-test controller for the standard-cell test structures in the user project (single-output cells with 1-3 inputs: AND/OR/NOR/AOI/INV/BUF).
- For each cell under test (CUT) it walks every input combination, drives the cell inputs, waits a programmable settle time, samples the output and compares it against a per-cell truth table.
- Reports a per-cell pass bitmap and a mismatch count.
- Sits between the management/LA configuration and the CUT instances, in place of direct io_in/io_out wiring.

Parameters:
- NCELLS, 11, number of CUTs sequenced (1..16).
- CNT_W, 16, width of the mismatch counter.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle start pulse; only accepted in IDLE.
- settle_i  in  8  settle cycles per vector; captured at an accepted start.
- nin_i  in  2*NCELLS  inputs per cell, 2 bits per cell; 0 = cell disabled; captured at start.
- tt_i  in  8*NCELLS  expected truth table, 8 bits per cell; bit v = expected Y for input vector v; captured at start.
- cut_out_i  in  NCELLS  CUT outputs Y.
- cut_in_o  out  3*NCELLS  CUT inputs; bit0 = A, bit1 = B, bit2 = C of each cell.
- busy_o  out  1  high from accepted start until DONE exits.
- done_o  out  1  one-cycle pulse at end of run.
- pass_o  out  NCELLS  per-cell result; valid when busy_o is low.
- fail_cnt_o  out  CNT_W  total mismatches; saturating.
- cur_cell_o  out  4  index of the cell being tested.
- cur_vec_o  out  3  current input vector.

Behaviour:
- Reset (sync, on wb_rst_i high at the clock edge): state IDLE, cut_in_o=0, busy_o=0, done_o=0, pass_o=0, fail_cnt_o=0, cur_cell_o=0, cur_vec_o=0.
- Reset mid-run aborts immediately to these values. No partial results are kept.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start_i: capture settle_i, nin_i and tt_i.
  - Set pass_o bit = 1 for every enabled cell (nin≠0) and 0 for disabled cells. Clear fail_cnt_o.
  - Select the first enabled cell with vec=0 and go to DRIVE.
  - If no cell is enabled, go directly to DONE.
  - start_i in any other state is ignored.
- DRIVE (1 cycle):
  - cut_in_o[3c+2:3c] = vec for the active cell c.
  - Every other cell's inputs = 0; unused input bits above nin = 0.
  - Load the settle counter with the captured settle value, then go to SETTLE. If settle = 0, go straight to SAMPLE.
- SETTLE: decrement the counter while cut_in_o is held; go to SAMPLE when the counter reaches 1.
- SAMPLE (1 cycle):
  - Compare cut_out_i[c] with tt[c][vec].
  - On mismatch: clear pass_o[c] and increment fail_cnt_o, saturating at all-ones with no wrap.
  - If vec < 2^nin - 1: vec+1, go to DRIVE.
  - Otherwise vec=0 and advance to the next enabled cell, go to DRIVE.
  - If there is no further enabled cell, go to DONE.
- DONE (1 cycle): done_o=1, cut_in_o=0, then IDLE. busy_o drops with the transition to IDLE.
- Per-vector latency = settle + 2 cycles (DRIVE + settle + SAMPLE). With settle = 0 it is 2 cycles.
- tt bits at index ≥ 2^nin are ignored. nin = 3 uses all 8 bits.
- pass_o and fail_cnt_o hold their values until the next accepted start.

Optional Feature:
- Macro CELL_TEST_SYNC_EN.
- When defined: cut_out_i passes through a 2-flop synchronizer before compare. The settle counter is loaded with settle+2, so per-vector latency = settle + 4. The synchronizer flops reset to 0.
- When undefined: cut_out_i is compared directly and latency is as stated above.

Decomposition:
- Shared package cell_test_pkg holds:
  - FSM state enum;
  - field widths: NIN_W=2, VEC_W=3, TT_W=8, CUT_IN_W=3;
  - helper function last_vec(nin) returning 2^nin - 1.
- One sub-module, cell_test_next_cell: combinational priority search for the next enabled cell index after c, plus a "none" flag. It is used from both IDLE and SAMPLE.

Test Plan:
- NCELLS=2; cell0 AND2 (nin=2, tt=8'h08) and cell1 INV (nin=1, tt=8'h01); ideal models; settle=3; start → 6 vectors at 5 cycles each, done_o pulses, pass_o=2'b11, fail_cnt_o=0.
- Same setup with cell0 output forced to 0 → pass_o=2'b10, fail_cnt_o=1, because only vector 3 mismatches.
- nin=0 for cell0 → cell0 is never driven (cut_in_o[2:0] stays 0), pass_o[0]=0, only 2 vectors run. All cells disabled → done_o pulses 1 cycle after start.
- settle=0 → cut_in_o changes every 2 cycles. start_i pulsed while busy → ignored, and the captured tt/nin are unaffected by mid-run input changes.
- wb_rst_i asserted in SETTLE → next cycle all outputs are 0 and state is IDLE. A fresh start then completes normally.
- CNT_W=2 with an always-wrong CUT over 8 vectors → fail_cnt_o saturates at 3. With CELL_TEST_SYNC_EN defined, per-vector period = settle + 4, checked at settle=1 (5 cycles).
